// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble): one shift-right plus
// per-digit subtract-3 correction per cycle, with a start/done handshake.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  error
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [BIN_W-1:0]   bin_q;
    logic               err_q;
    logic               bad_digit;

    // One reverse double-dabble step: shift, then pull every digit >= 8 back by 3.
    always_comb begin
        sr_d = sr_q >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_d[BIN_W+4*i +: 4] >= 4'd8) begin
                sr_d[BIN_W+4*i +: 4] = sr_d[BIN_W+4*i +: 4] - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (bad_digit) begin
                            bin_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            sr_q    <= {bcd_in, {BIN_W{1'b0}}};
                            cnt_q   <= '0;
                            state_q <= CONV;
                        end
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    // The BCD field has drained to zero after BIN_W steps.
                    if (cnt_q == CNT_W'(BIN_W - 1)) begin
                        bin_q   <= sr_d[BIN_W-1:0];
                        err_q   <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready   = (state_q == IDLE);
    assign busy    = (state_q == CONV);
    assign done    = (state_q == DONE);
    assign bin_out = bin_q;
    assign error   = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Directed plus randomized bench for bcd_to_bin_seq, checked against a decimal
// arithmetic reference model.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] bcd_in;
    logic        ready;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        error;

    int n_cmp;
    int n_bad;

    bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bcd_in  (bcd_in),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: value of the decimal digits, and whether any digit is not decimal.
    function automatic int ref_err(input logic [11:0] bcd);
        int e;
        e = 0;
        for (int i = 0; i < 3; i++) begin
            if (((bcd >> (4 * i)) & 12'hF) > 9) e = 1;
        end
        return e;
    endfunction

    function automatic int ref_bin(input logic [11:0] bcd);
        int v;
        int w;
        v = 0;
        w = 1;
        for (int i = 0; i < 3; i++) begin
            v = v + int'((bcd >> (4 * i)) & 12'hF) * w;
            w = w * 10;
        end
        return (ref_err(bcd) != 0) ? 0 : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start one conversion and watch a 16-cycle window; with disturb set, a
    // request for 12'h777 is pulsed in cycle 3 and in the expected done cycle.
    task automatic run_one(input logic [11:0] bcd, input bit disturb);
        int eb;
        int ee;
        int exp_cyc;
        int done_n;
        int busy_n;
        int done_cyc;
        eb      = ref_bin(bcd);
        ee      = ref_err(bcd);
        exp_cyc = (ee != 0) ? 1 : 11;
        done_n  = 0;
        busy_n  = 0;
        done_cyc = 0;
        @(negedge clk);
        chk("ready_before_start", int'(ready), 1);
        start  = 1'b1;
        bcd_in = bcd;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    done_cyc = cyc;
                    chk("bin_out_at_done", int'(bin_out), eb);
                    chk("error_at_done", int'(error), ee);
                end
            end
            if (busy) busy_n++;
            if (cyc == exp_cyc + 1) chk("ready_after_done", int'(ready), 1);
            start  = disturb && (cyc == 3 || cyc == exp_cyc);
            bcd_in = disturb ? 12'h777 : 12'($urandom);
        end
        start = 1'b0;
        chk("done_cycle", done_cyc, exp_cyc);
        chk("done_pulses", done_n, 1);
        chk("busy_cycles", busy_n, (ee != 0) ? 0 : 10);
        chk("bin_out_held", int'(bin_out), eb);
        chk("error_held", int'(error), ee);
    endtask

    initial begin
        int done_n;
        int next_done;
        logic [11:0] rb;
        n_cmp  = 0;
        n_bad  = 0;
        reset  = 1'b1;
        start  = 1'b0;
        bcd_in = 12'h000;
        #1;
        chk("rst_ready", int'(ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_bin_out", int'(bin_out), 0);
        chk("rst_error", int'(error), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_one(12'h000, 1'b0);
        run_one(12'h999, 1'b0);
        run_one(12'h255, 1'b0);
        run_one(12'h512, 1'b0);
        run_one(12'h1A3, 1'b0);
        run_one(12'h042, 1'b0);
        run_one(12'h123, 1'b1);

        // Random values, mostly decimal with an occasional non-decimal digit.
        for (int k = 0; k < 12; k++) begin
            rb = 12'h000;
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 7) == 0) rb[4*i +: 4] = 4'($urandom_range(10, 15));
                else                           rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            run_one(rb, 1'b0);
        end

        // start held high: one conversion every 12 cycles.
        @(negedge clk);
        start     = 1'b1;
        bcd_in    = 12'h500;
        done_n    = 0;
        next_done = 11;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_n++;
                chk("held_done_cycle", cyc, next_done);
                chk("held_bin_out", int'(bin_out), 500);
                next_done = next_done + 12;
            end
        end
        start = 1'b0;
        chk("held_done_count", done_n, 3);

        // Asynchronous reset in the middle of cycle 5 of a conversion.
        @(negedge clk);
        @(negedge clk);
        start  = 1'b1;
        bcd_in = 12'h999;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_ready", int'(ready), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_bin_out", int'(bin_out), 0);
        chk("midrst_error", int'(error), 0);
        @(negedge clk);
        reset  = 1'b0;
        done_n = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            @(negedge clk);
            if (done) done_n++;
        end
        chk("midrst_no_done", done_n, 0);
        run_one(12'h008, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
Name: bcd_to_bin_seq

Overview:
- Iterative BCD-to-binary converter using reverse double-dabble: shift right one bit, then subtract 3 from every BCD digit that is >= 8.
- This is the inverse of the display path's add-3 binary-to-BCD digit correction.
- Turns keypad- or display-side BCD values back into binary for the arithmetic datapath.
- Start/done handshake; one conversion in flight at a time.

Parameters:
- DIGITS, 3, number of BCD digits in bcd_in.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W > 10^DIGITS - 1. Not checked in RTL; behaviour is undefined if violated.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion; sampled only while ready=1.
- bcd_in  input  4*DIGITS  packed BCD; digit 0 is in bits [3:0]; sampled on the accepting edge.
- ready  output  1  block is idle and accepts start.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse; bin_out and error are valid from this cycle.
- bin_out  output  BIN_W  binary result; holds until the next done.
- error  output  1  last accepted bcd_in contained a digit > 9; holds until the next done.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, shift register=0, iteration counter=0.
  - bin_out=0, error=0, done=0, busy=0, ready=1.
- Reset mid-conversion aborts the conversion: no done pulse, outputs return to reset values.
- State machine has three states: IDLE, CONV, DONE.
  - ready=1 only in IDLE.
  - busy=1 only in CONV.
  - done=1 only in DONE.
  - All three are decoded from the registered state.
- IDLE:
  - On an edge with start=1, capture bcd_in and check every digit.
  - If any digit > 9: go to DONE with error<=1 and bin_out<=0; no CONV cycles run.
  - Otherwise: load the shift register {bcd, bin} = {bcd_in, BIN_W'b0}, set counter=0, go to CONV.
  - start=0 keeps the block in IDLE.
- CONV: each cycle performs exactly one iteration.
  - Shift the whole (4*DIGITS+BIN_W)-bit register right by 1; the MSB is filled with 0.
  - After the shift, every 4-bit BCD digit >= 8 has 3 subtracted, modulo 4 bits.
  - All digits are adjusted in parallel within the same cycle.
  - counter increments each iteration.
  - After the iteration with counter=BIN_W-1, go to DONE.
  - bin_out <= the bin field of the post-iteration register; error <= 0.
  - The BCD field is necessarily 0 at this point.
- DONE: lasts one cycle, then IDLE. start is ignored in DONE because ready=0.
- Latency, with start accepted at edge 0:
  - Valid input: CONV occupies cycles 1..BIN_W; done=1 in cycle BIN_W+1 (cycle 11 at default).
  - Invalid input: done=1 in cycle 1.
  - start held high continuously gives one conversion every BIN_W+2 cycles (12 at default).
- start while busy or done is dropped. It is not queued, and bcd_in changes during CONV have no effect.
- bin_out and error change only on the edge entering DONE; they are stable at all other times.
- All outputs are registered or decoded from registered state; no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with bcd_in=12'h000 -> done in cycle 11; bin_out=10'd0, error=0; ready returns to 1 in cycle 12.
- bcd_in=12'h999 -> bin_out=10'h3E7 (999); bcd_in=12'h255 -> 10'h0FF; bcd_in=12'h512 -> 10'h200. Each has done in cycle 11 and error=0.
- Invalid input:
  - bcd_in=12'h1A3 -> done in cycle 1, error=1, bin_out=0, busy never asserts.
  - Follow with bcd_in=12'h042 -> bin_out=10'd42, error=0.
- Dropped requests:
  - Start 12'h123, then pulse start with bcd_in=12'h777 during cycles 3 and 11 (the DONE cycle).
  - Required: bin_out=10'd123, exactly one done pulse, and 12'h777 is never converted.
- start held high with bcd_in=12'h500 -> done pulses in cycles 11, 23, 35, ..., each with bin_out=10'd500.
- Start 12'h999, assert reset asynchronously mid-cycle 5 -> outputs immediately return to reset values; no done pulse; a following 12'h008 converts to 10'd8.
